// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the repeated-subtraction binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    OUT
  } state_t;

  function automatic logic [63:0] pow10(input int unsigned k);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < k; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_subtractor_nbit.sv
// N-bit adder/subtractor; add_n=1 computes x - y, with c_out=1 meaning no borrow (x >= y).
module adder_subtractor_nbit #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out
);

  logic [n-1:0] y_eff;

  always_comb begin
    y_eff        = y ^ {n{add_n}};
    {c_out, s}   = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
  end

endmodule

// File: rtl/bin2bcd_sub_ctrl.sv
// Sequential binary-to-BCD converter: peels off powers of ten one subtraction per cycle
// through a single shared adder/subtractor, with valid/ready on both sides.
module bin2bcd_sub_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int unsigned DW    = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;
  localparam logic [DW-1:0] D_TOP = DW'(DIGITS - 1);

  if (!((pow10(DIGITS - 1) < (64'd1 << N)) && ((64'd1 << N) <= pow10(DIGITS)))) begin : g_bad_params
    $error("bin2bcd_sub_ctrl: DIGITS does not match N");
  end

  state_t              state_q, state_d;
  logic [N-1:0]        r_q, r_d;
  logic [DW-1:0]       d_q, d_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [N-1:0]        pow10_sel;
  logic [N-1:0]        diff;
  logic                ge;

  always_comb begin
    pow10_sel = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (d_q == DW'(i)) begin
        pow10_sel = N'(pow10(i));
      end
    end
  end

  adder_subtractor_nbit #(
    .n(N)
  ) u_addsub (
    .x    (r_q),
    .y    (pow10_sel),
    .add_n(1'b1),
    .s    (diff),
    .c_out(ge)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = bin;
          bcd_d   = '0;
          d_d     = D_TOP;
          state_d = SUB;
        end
      end
      SUB: begin
        if (ge) begin
          r_d = diff;
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (d_q == DW'(i)) begin
              bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            end
          end
        end else if (d_q == DW'(1)) begin
          // remainder is already below ten here, so it is the ones digit
          bcd_d[3:0] = r_q[3:0];
          state_d    = OUT;
        end else begin
          d_d = d_q - DW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= D_TOP;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign bcd       = bcd_q;

endmodule
